// File: rtl/command_encoder.sv
// Memory command encoder: accepts one command at a time, issues a one-hot strobe
// and enforces a per-command idle time. Build macro CMD_ENC_ROW_CHECK_EN adds open-row legality checks.
module command_encoder #(
  parameter logic [7:0] T_RW  = 8'd1,
  parameter logic [7:0] T_ACT = 8'd3,
  parameter logic [7:0] T_PRE = 8'd3,
  parameter logic [7:0] T_REF = 8'd8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_code,
  input  logic [31:0] cmd_addr,
  output logic        cmd_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        activate,
  output logic        precharge,
  output logic        refresh,
  output logic [31:0] addr,
  output logic        err_illegal,
  output logic        row_open
);

  // state | meaning
  // IDLE  | cmd_ready=1, waiting for a command
  // ISSUE | single strobe cycle, addr carries the accepted address
  // WAIT  | down-counter holds off new commands for the command's T_* cycles
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  localparam logic [3:0] CODE_READ  = 4'd1;
  localparam logic [3:0] CODE_WRITE = 4'd2;
  localparam logic [3:0] CODE_ACT   = 4'd3;
  localparam logic [3:0] CODE_PRE   = 4'd4;
  localparam logic [3:0] CODE_REF   = 4'd5;

  state_t     state;
  logic [7:0] cnt;

  logic [4:0] strb_sel;  // {refresh, precharge, activate, mem_write, mem_read}
  logic [7:0] t_sel;
  logic       code_known;
  logic       row_ok;
  logic       cmd_legal;
  logic       accept;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    strb_sel   = 5'b00000;
    t_sel      = 8'd0;
    code_known = 1'b1;
    case (cmd_code)
      CODE_READ:  begin strb_sel = 5'b00001; t_sel = T_RW;  end
      CODE_WRITE: begin strb_sel = 5'b00010; t_sel = T_RW;  end
      CODE_ACT:   begin strb_sel = 5'b00100; t_sel = T_ACT; end
      CODE_PRE:   begin strb_sel = 5'b01000; t_sel = T_PRE; end
      CODE_REF:   begin strb_sel = 5'b10000; t_sel = T_REF; end
      default:    code_known = 1'b0;
    endcase
  end

`ifdef CMD_ENC_ROW_CHECK_EN
  // Column access needs an open row; activate and refresh need it closed.
  always_comb begin
    row_ok = 1'b1;
    case (cmd_code)
      CODE_READ, CODE_WRITE: row_ok = row_open;
      CODE_ACT, CODE_REF:    row_ok = !row_open;
      default:               row_ok = 1'b1;
    endcase
  end
`else
  assign row_ok = 1'b1;
`endif

  assign cmd_legal = code_known && row_ok;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      cmd_ready   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      activate    <= 1'b0;
      precharge   <= 1'b0;
      refresh     <= 1'b0;
      addr        <= 32'd0;
      err_illegal <= 1'b0;
      row_open    <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            if (cmd_legal) begin
              state     <= ST_ISSUE;
              cmd_ready <= 1'b0;
              cnt       <= t_sel;
              addr      <= cmd_addr;
              {refresh, precharge, activate, mem_write, mem_read} <= strb_sel;
              if (strb_sel[2]) begin
                row_open <= 1'b1;
              end else if (strb_sel[3]) begin
                row_open <= 1'b0;
              end
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          {refresh, precharge, activate, mem_write, mem_read} <= 5'b00000;
          if (cnt == 8'd0) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Terminal count: leave on the cycle after the counter shows 1.
          if (cnt <= 8'd1) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            cnt       <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
          cnt       <= 8'd0;
          {refresh, precharge, activate, mem_write, mem_read} <= 5'b00000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_command_encoder.sv
// Bench for command_encoder: vector table plus scoreboard of strobe/error events,
// and hand sequences for held requests, reset mid-WAIT and T_RW=0 back-to-back.
module tb_command_encoder;

  logic        sys_clk;
  logic        sys_rst;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        cmd_ready, mem_read, mem_write, activate, precharge, refresh;
  logic [31:0] addr;
  logic        err_illegal, row_open;

  logic        v0;
  logic [3:0]  c0;
  logic [31:0] a0;
  logic        r0, rd0, wr0, act0, pre0, ref0, err0, row0;
  logic [31:0] addr0;

  command_encoder dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_addr(cmd_addr), .cmd_ready(cmd_ready), .mem_read(mem_read), .mem_write(mem_write),
    .activate(activate), .precharge(precharge), .refresh(refresh), .addr(addr),
    .err_illegal(err_illegal), .row_open(row_open)
  );

  command_encoder #(.T_RW(8'd0)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(v0), .cmd_code(c0),
    .cmd_addr(a0), .cmd_ready(r0), .mem_read(rd0), .mem_write(wr0),
    .activate(act0), .precharge(pre0), .refresh(ref0), .addr(addr0),
    .err_illegal(err0), .row_open(row0)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // {refresh, precharge, activate, mem_write, mem_read}
  localparam logic [4:0] S_RD = 5'b00001, S_WR = 5'b00010, S_ACT = 5'b00100,
                         S_PRE = 5'b01000, S_REF = 5'b10000, S_NONE = 5'b00000;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [4:0]  strb;
    logic        err;
    logic [31:0] eaddr;
    logic        row;
    int          t;
  } vec_t;

  logic [38:0] sb[$];
  logic [38:0] e;
  logic [4:0]  strobes;
  assign strobes = {refresh, precharge, activate, mem_write, mem_read};

  always @(negedge sys_clk) begin
    if (!sys_rst && (strobes != 5'b0 || err_illegal)) begin
      if (sb.size() == 0) begin
        chk("sb_spurious", {58'd0, strobes, err_illegal}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_event", {25'd0, strobes, err_illegal, addr, row_open}, {25'd0, e});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("ready_wait", cmd_ready, 1);
  endtask

  vec_t vec[12];
  int   n, rd_c, wr_c;

  initial begin
    vec[0]  = '{4'd3,  32'h0000_1000, S_ACT,  1'b0, 32'h0000_1000, 1'b1, 3};
    vec[1]  = '{4'd1,  32'h0000_2000, S_RD,   1'b0, 32'h0000_2000, 1'b1, 1};
    vec[2]  = '{4'd2,  32'h0000_2004, S_WR,   1'b0, 32'h0000_2004, 1'b1, 1};
    vec[3]  = '{4'd7,  32'hdead_0007, S_NONE, 1'b1, 32'h0000_2004, 1'b1, 0};
    vec[4]  = '{4'd0,  32'hdead_0000, S_NONE, 1'b1, 32'h0000_2004, 1'b1, 0};
    vec[5]  = '{4'd15, 32'hdead_000f, S_NONE, 1'b1, 32'h0000_2004, 1'b1, 0};
    vec[6]  = '{4'd4,  32'h0000_3000, S_PRE,  1'b0, 32'h0000_3000, 1'b0, 3};
    vec[7]  = '{4'd5,  32'h0000_4000, S_REF,  1'b0, 32'h0000_4000, 1'b0, 8};
`ifdef CMD_ENC_ROW_CHECK_EN
    vec[8]  = '{4'd2,  32'h0000_5000, S_NONE, 1'b1, 32'h0000_4000, 1'b0, 0};
`else
    vec[8]  = '{4'd2,  32'h0000_5000, S_WR,   1'b0, 32'h0000_5000, 1'b0, 1};
`endif
    vec[9]  = '{4'd3,  32'h0000_6000, S_ACT,  1'b0, 32'h0000_6000, 1'b1, 3};
    vec[10] = '{4'd6,  32'hdead_0006, S_NONE, 1'b1, 32'h0000_6000, 1'b1, 0};
    vec[11] = '{4'd4,  32'h0000_7000, S_PRE,  1'b0, 32'h0000_7000, 1'b0, 3};

    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_code = 4'd0; cmd_addr = 32'd0;
    v0 = 1'b0; c0 = 4'd0; a0 = 32'd0;

    #3;
    chk("rst_outputs", {cmd_ready, strobes, err_illegal, row_open, addr}, 64'd0);
    chk("rst_outputs0", {r0, rd0, wr0, act0, pre0, ref0, err0, row0, addr0}, 64'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("rst_hold_ready", cmd_ready, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("ready_after_release", cmd_ready, 1);

    for (int i = 0; i < 12; i++) begin
      wait_ready();
      cmd_valid = 1'b1; cmd_code = vec[i].code; cmd_addr = vec[i].a;
      sb.push_back({vec[i].strb, vec[i].err, vec[i].eaddr, vec[i].row});
      @(posedge sys_clk);
      #1 cmd_valid = 1'b0;
      @(negedge sys_clk);
      if (vec[i].err) begin
        chk("ready_after_illegal", cmd_ready, 1);
      end else begin
        n = 0;
        while (!cmd_ready && n < 300) begin
          n++;
          @(negedge sys_clk);
        end
        chk("ready_low_cycles", n, vec[i].t + 1);
      end
    end

    // Refresh, with a read request held through the whole idle window.
    wait_ready();
    cmd_valid = 1'b1; cmd_code = 4'd5; cmd_addr = 32'h0000_8000;
    sb.push_back({S_REF, 1'b0, 32'h0000_8000, 1'b0});
`ifdef CMD_ENC_ROW_CHECK_EN
    sb.push_back({S_NONE, 1'b1, 32'h0000_8000, 1'b0});
`else
    sb.push_back({S_RD, 1'b0, 32'h0000_8004, 1'b0});
`endif
    @(posedge sys_clk);
    #1 cmd_code = 4'd1; cmd_addr = 32'h0000_8004;
    @(negedge sys_clk);
    chk("held_refresh_strobe", refresh, 1);
    @(negedge sys_clk);
    n = 1;
    while (!cmd_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("held_ready_gap", n, 9);
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("held_accept", mem_read | err_illegal, 1);
    chk("held_ready_drop", cmd_ready, 0);
    @(negedge sys_clk);
    wait_ready();

    // Reset in the middle of a refresh WAIT.
    cmd_valid = 1'b1; cmd_code = 4'd5; cmd_addr = 32'h0000_9000;
    sb.push_back({S_REF, 1'b0, 32'h0000_9000, 1'b0});
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 chk("async_reset_zero", {cmd_ready, strobes, err_illegal, row_open, addr}, 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1 chk("ready_before_edge", cmd_ready, 0);
    @(negedge sys_clk);
    chk("ready_first_edge", cmd_ready, 1);
    repeat (12) @(negedge sys_clk);
    chk("sb_drained", sb.size(), 0);

    // T_RW=0 instance: activate, then read and write back to back.
    v0 = 1'b1; c0 = 4'd3; a0 = 32'h0000_a000;
    @(posedge sys_clk);
    #1 v0 = 1'b0;
    @(negedge sys_clk);
    chk("rw0_activate", act0, 1);
    n = 0;
    while (!r0 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("rw0_ready", r0, 1);
    v0 = 1'b1; c0 = 4'd1; a0 = 32'h0000_b000;
    @(posedge sys_clk);
    #1 c0 = 4'd2; a0 = 32'h0000_b004;
    rd_c = 0; wr_c = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge sys_clk);
      if (rd0) rd_c = k;
      if (wr0) wr_c = k;
      if (k == 2) begin
        @(posedge sys_clk);
        #1 v0 = 1'b0;
      end
    end
    chk("rw0_read_cycle", rd_c, 1);
    chk("rw0_write_cycle", wr_c, 3);
    chk("rw0_addr", addr0, 32'h0000_b004);
    chk("rw0_no_error", err0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
